// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard control logic.
package mips_pipe_pkg;

    // Width of a general-purpose register index.
    localparam int REG_IDX_W = 5;

    // Width of the mul/div busy down-counter; bounds MD_LATENCY to 1..4.
    localparam int MD_CNT_W = 2;

    // Mul/div unit tracking state.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Pipeline steering controls produced every cycle.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_bubble;
    } hz_ctrl_t;

    // No hazard: everything advances, nothing is squashed.
    localparam hz_ctrl_t CTRL_PASS = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_bubble: 1'b0
    };

    // Data memory stall: hold IF..EX, let MEM/WB drain with a bubble.
    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0, exmem_write: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_bubble: 1'b1
    };

    // Taken branch in MEM: squash the three younger instructions.
    localparam hz_ctrl_t CTRL_FLUSH = '{
        pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_bubble: 1'b0
    };

    // Interlock: hold PC and IF/ID, insert a bubble into ID/EX.
    localparam hz_ctrl_t CTRL_ID_BUBBLE = '{
        pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b1, exmem_write: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0, memwb_bubble: 1'b0
    };

    // Load in EX writes a register the ID instruction reads; r0 never counts.
    function automatic logic load_use_hit(
        input logic                 ex_mem_read,
        input logic [REG_IDX_W-1:0] ex_target,
        input logic [REG_IDX_W-1:0] id_rs,
        input logic [REG_IDX_W-1:0] id_rt,
        input logic                 id_uses_rt
    );
        return ex_mem_read && (ex_target != '0) &&
               ((ex_target == id_rs) || (id_uses_rt && (ex_target == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count up until all-ones, then hold; clear takes precedence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, mul/div
// HI/LO interlock, taken-branch flush and data-memory freeze, plus a
// saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MD_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_IDX_W-1:0]   ID_RS,
    input  logic [REG_IDX_W-1:0]   ID_RT,
    input  logic                   ID_UsesRT,
    input  logic                   ID_MulDiv,
    input  logic                   ID_ReadsHILO,
    input  logic                   EX_MemRead,
    input  logic [REG_IDX_W-1:0]   EX_target,
    input  logic                   EX_MulDiv,
    input  logic                   MEM_BranchTaken,
    input  logic                   Dmem_wait,
    input  logic                   Stall_clr,
    output logic                   PC_Write,
    output logic                   IFID_Write,
    output logic                   IDEX_Write,
    output logic                   EXMEM_Write,
    output logic                   IFID_Flush,
    output logic                   IDEX_Flush,
    output logic                   EXMEM_Flush,
    output logic                   MEMWB_Bubble,
    output logic                   MulDiv_busy,
    output logic [STALL_CNT_W-1:0] Stall_count
);

    // Reload value so that the unit reports busy for exactly MD_LATENCY cycles
    // (counts MD_LATENCY-1 down to 0 inclusive). MD_LATENCY must be 1..4.
    localparam logic [MD_CNT_W-1:0] MD_CNT_INIT = MD_CNT_W'(MD_LATENCY - 1);

    md_state_e             state_q;
    logic [MD_CNT_W-1:0]   md_cnt_q;
    hz_ctrl_t              ctrl;
    logic                  md_interlock;
    logic                  load_use;
    logic                  md_start;
    logic                  stall_cycle;

    // An instruction touching HI/LO must wait while the unit is starting or busy.
    assign md_interlock = (ID_ReadsHILO || ID_MulDiv) && (EX_MulDiv || (state_q == MD_BUSY));
    assign load_use     = load_use_hit(EX_MemRead, EX_target, ID_RS, ID_RT, ID_UsesRT);

    // A mul/div only launches if it actually leaves EX this cycle.
    assign md_start = (state_q == MD_IDLE) && EX_MulDiv && !Dmem_wait && !MEM_BranchTaken;

    // Priority decode: freeze > flush > mul/div interlock > load-use > pass.
    always_comb begin
        // NOTE: ctrl gets a default before the priority chain so every path
        // assigns it and no latch is inferred.
        ctrl = CTRL_PASS;
        if (Dmem_wait) begin
            ctrl = CTRL_FREEZE;
        end else if (MEM_BranchTaken) begin
            ctrl = CTRL_FLUSH;
        end else if (md_interlock || load_use) begin
            ctrl = CTRL_ID_BUBBLE;
        end
    end

    // Mul/div tracking FSM; the counter runs regardless of pipeline freezes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_i) begin
            state_q  <= MD_IDLE;
            md_cnt_q <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (md_start) begin
                        state_q  <= MD_BUSY;
                        md_cnt_q <= MD_CNT_INIT;
                    end
                end
                MD_BUSY: begin
                    // A mul/div appearing in EX here is ignored: no restart.
                    if (md_cnt_q == '0) begin
                        state_q <= MD_IDLE;
                    end else begin
                        md_cnt_q <= md_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q  <= MD_IDLE;
                    md_cnt_q <= '0;
                end
            endcase
        end
    end

    assign PC_Write     = ctrl.pc_write;
    assign IFID_Write   = ctrl.ifid_write;
    assign IDEX_Write   = ctrl.idex_write;
    assign EXMEM_Write  = ctrl.exmem_write;
    assign IFID_Flush   = ctrl.ifid_flush;
    assign IDEX_Flush   = ctrl.idex_flush;
    assign EXMEM_Flush  = ctrl.exmem_flush;
    assign MEMWB_Bubble = ctrl.memwb_bubble;
    assign MulDiv_busy  = (state_q == MD_BUSY);

    // Any cycle in which the PC is held counts as a stall cycle.
    assign stall_cycle = !ctrl.pc_write;

    sat_counter #(
        .WIDTH (STALL_CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_i),
        .inc_i   (stall_cycle),
        .clr_i   (Stall_clr),
        .count_o (Stall_count)
    );

endmodule
